riscv_memalign_split: RTL and testbench

//  Memory-side counterpart of the misalignment check: executes a CPU data access whose

---
 rtl/riscv_mpsoc_pkg.sv | 22 ++
 rtl/riscv_memalign_split_if.sv | 26 ++
 rtl/riscv_memalign_lanes.sv | 44 ++++
 rtl/riscv_memalign_split.sv | 140 ++++++++++++++
 tb/tb_riscv_memalign_split.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mpsoc_pkg.sv
// rtl/riscv_mpsoc_pkg.sv - shared access-size encodings and memalign FSM states
package riscv_mpsoc_pkg;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HWORD = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] DWORD = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1
    } memalign_state_t;

    // DWORD only exists on a 64-bit datapath
    function automatic logic size_legal(input logic [2:0] size, input int xlen);
        return (size <= DWORD) && !((size == DWORD) && (xlen == 32));
    endfunction

endpackage

// File: rtl/riscv_memalign_split_if.sv
// rtl/riscv_memalign_split_if.sv - word-aligned data bus between memalign unit and memory
interface riscv_memalign_split_if #(
    parameter int XLEN = 64
) ();
    localparam int NB = XLEN / 8;

    logic            mem_req;
    logic            mem_ack;
    logic [XLEN-1:0] mem_adr;
    logic            mem_we;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_d;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_q;
    logic            mem_err;

    modport master (
        output mem_req, mem_adr, mem_we, mem_be, mem_d,
        input  mem_ack, mem_rvalid, mem_q, mem_err
    );

    modport slave (
        input  mem_req, mem_adr, mem_we, mem_be, mem_d,
        output mem_ack, mem_rvalid, mem_q, mem_err
    );
endinterface

// File: rtl/riscv_memalign_lanes.sv
// rtl/riscv_memalign_lanes.sv - byte enables, write rotation and read merge for a split access
module riscv_memalign_lanes #(
    parameter  int XLEN = 64,
    localparam int NB   = XLEN / 8,
    localparam int OFS  = $clog2(NB)
) (
    input  logic [OFS-1:0]  off,
    input  logic [1:0]      size,
    input  logic            split,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    output logic [NB-1:0]   be0,
    output logic [NB-1:0]   be1,
    output logic [XLEN-1:0] wdata_rot,
    output logic [XLEN-1:0] rdata
);

    logic [3:0]      n;
    logic [2*NB-1:0] span;
    int              lane;

    // span covers both beats: low half is beat0 lanes, high half spills into beat1
    always_comb begin
        n         = 4'd1 << size;
        span      = (((2*NB)'(1) << n) - (2*NB)'(1)) << off;
        be0       = span[NB-1:0];
        be1       = split ? span[2*NB-1:NB] : '0;
        wdata_rot = '0;
        rdata     = '0;
        lane      = 0;
        for (int i = 0; i < NB; i++) begin
            lane = (i + int'(off)) % NB;
            wdata_rot[8*lane +: 8] = wdata[8*i +: 8];
        end
        for (int i = 0; i < NB; i++) begin
            lane = int'(off) + i;
            if (i < int'(n)) begin
                rdata[8*i +: 8] = (lane < NB) ? beat0[8*lane +: 8] : beat1[8*(lane-NB) +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_memalign_split.sv
// rtl/riscv_memalign_split.sv - executes word-crossing CPU accesses as two aligned bus beats
module riscv_memalign_split
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] adr_i,
    input  logic [2:0]      size_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    output logic            rvalid_o,
    output logic [XLEN-1:0] q_o,
    output logic            err_o,
    riscv_memalign_split_if.master bus
);

    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    memalign_state_t state_q, state_d;

    logic [XLEN-1:0] adr_q, d_q, beat0_q, q_q;
    logic [1:0]      size_q;
    logic            we_q, rvalid_q, err_q;
    logic            legal, split;
    logic [OFS-1:0]  off;
    logic [OFS+1:0]  end_byte;
    logic [NB-1:0]   be0, be1;
    logic [XLEN-1:0] wdata_rot, rdata, merge_beat0, word_adr;

    assign legal    = size_legal(size_i, XLEN);
    assign off      = adr_q[OFS-1:0];
    assign end_byte = (OFS+2)'(off) + ((OFS+2)'(1) << size_q);
    assign split    = end_byte > (OFS+2)'(NB);
    assign word_adr = {adr_q[XLEN-1:OFS], {OFS{1'b0}}};

    // a non-split access completes from RSP0, so beat0 comes straight off the bus there
    assign merge_beat0 = (state_q == RSP0) ? bus.mem_q : beat0_q;

    riscv_memalign_lanes #(.XLEN(XLEN)) u_lanes (
        .off       (off),
        .size      (size_q),
        .split     (split),
        .wdata     (d_q),
        .beat0     (merge_beat0),
        .beat1     (bus.mem_q),
        .be0       (be0),
        .be1       (be1),
        .wdata_rot (wdata_rot),
        .rdata     (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_o     = (state_q == IDLE);
        bus.mem_req = 1'b0;
        bus.mem_adr = '0;
        bus.mem_we  = 1'b0;
        bus.mem_be  = '0;
        bus.mem_d   = '0;
        case (state_q)
            IDLE: if (req_i && legal) state_d = REQ0;
            REQ0: begin
                bus.mem_req = 1'b1;
                bus.mem_adr = word_adr;
                bus.mem_we  = we_q;
                bus.mem_be  = be0;
                bus.mem_d   = wdata_rot;
                if (bus.mem_ack) state_d = RSP0;
            end
            RSP0: if (bus.mem_rvalid) state_d = (bus.mem_err || !split) ? IDLE : REQ1;
            REQ1: begin
                bus.mem_req = 1'b1;
                bus.mem_adr = word_adr + XLEN'(NB);
                bus.mem_we  = we_q;
                bus.mem_be  = be1;
                bus.mem_d   = wdata_rot;
                if (bus.mem_ack) state_d = RSP1;
            end
            RSP1: if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adr_q    <= '0;
            d_q      <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            beat0_q  <= '0;
            q_q      <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (state_q == IDLE && req_i) begin
                adr_q  <= adr_i;
                size_q <= size_i[1:0];
                we_q   <= we_i;
                d_q    <= d_i;
                if (!legal) begin
                    rvalid_q <= 1'b1;
                    err_q    <= 1'b1;
                end
            end
            if (state_q == RSP0 && bus.mem_rvalid) begin
                beat0_q <= bus.mem_q;
                if (bus.mem_err || !split) begin
                    rvalid_q <= 1'b1;
                    err_q    <= bus.mem_err;
                    if (!we_q) q_q <= rdata;
                end
            end
            // beat0 was error-free to get here, so beat1 alone decides err
            if (state_q == RSP1 && bus.mem_rvalid) begin
                rvalid_q <= 1'b1;
                err_q    <= bus.mem_err;
                if (!we_q) q_q <= rdata;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = rvalid_q & err_q;
    assign q_o      = q_q;

endmodule

// File: tb/tb_riscv_memalign_split.sv
// tb/tb_riscv_memalign_split.sv - scoreboard bench for riscv_memalign_split against a byte-memory model
module tb_riscv_memalign_split;

    localparam int XLEN = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic [63:0] adr = '0;
    logic [2:0]  size = '0;
    logic        we = 1'b0;
    logic [63:0] d = '0;
    logic        rvalid;
    logic [63:0] q;
    logic        err;

    riscv_memalign_split_if #(.XLEN(XLEN)) bus ();

    riscv_memalign_split #(.XLEN(XLEN)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .ready_o  (ready),
        .adr_i    (adr),
        .size_i   (size),
        .we_i     (we),
        .d_i      (d),
        .rvalid_o (rvalid),
        .q_o      (q),
        .err_o    (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] q;
        logic        err;
        logic        load;
        int          beats;
        int          t_acc;
        int          lat;
        int          base;
    } exp_t;

    typedef struct {
        logic [63:0] adr;
        logic [7:0]  be;
        logic [63:0] d;
        logic        we;
    } beat_t;

    exp_t  exp_q[$];
    beat_t blog[$];

    logic [7:0] ref_mem [logic [63:0]];
    logic [7:0] bus_mem [logic [63:0]];

    int  max_wait = 0;
    int  force_wait = -1;
    bit  inject_err = 0;
    int  beat_cnt = 0;
    logic [63:0] last_q = '0;
    bit  q_known = 1;

    function automatic logic [7:0] init_b(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
    endfunction

    function automatic logic [7:0] bus_rd(input logic [63:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_b(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            ref_mem[a + 64'(i)] = w[8*i +: 8];
            bus_mem[a + 64'(i)] = w[8*i +: 8];
        end
    endtask

    // memory responder: random or forced ack delay, response one cycle after ack
    initial begin : responder
        bit          pend, held;
        int          wait_left;
        logic [63:0] pend_q, snap_adr, snap_d;
        logic [7:0]  snap_be;
        logic        pend_err;
        pend = 0; held = 0; wait_left = 0;
        pend_q = '0; pend_err = 0; snap_adr = '0; snap_d = '0; snap_be = '0;
        bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_q = '0; bus.mem_err = 0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_err = 0;
            if (!rst_n) begin
                pend = 0; held = 0;
            end else begin
                if (pend) begin
                    bus.mem_rvalid = 1; bus.mem_q = pend_q; bus.mem_err = pend_err; pend = 0;
                end
                if (bus.mem_req) begin
                    if (!held) begin
                        held = 1;
                        snap_adr = bus.mem_adr; snap_be = bus.mem_be; snap_d = bus.mem_d;
                        wait_left = (force_wait >= 0) ? force_wait : $urandom_range(max_wait, 0);
                    end else begin
                        check("hold_adr", bus.mem_adr, snap_adr);
                        check("hold_be", 64'(bus.mem_be), 64'(snap_be));
                        check("hold_d", bus.mem_d, snap_d);
                    end
                    if (wait_left == 0) begin
                        bus.mem_ack = 1; held = 0; beat_cnt++;
                        check("beat_align", 64'(bus.mem_adr[2:0]), 64'd0);
                        blog.push_back('{adr: bus.mem_adr, be: bus.mem_be, d: bus.mem_d, we: bus.mem_we});
                        pend_q = '0;
                        for (int i = 0; i < 8; i++) begin
                            if (bus.mem_we && bus.mem_be[i]) bus_mem[bus.mem_adr + 64'(i)] = bus.mem_d[8*i +: 8];
                            pend_q[8*i +: 8] = bus_rd(bus.mem_adr + 64'(i));
                        end
                        pend_err = inject_err; inject_err = 0; pend = 1;
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // scoreboard monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rvalid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rvalid: got rvalid_o=1 want no completion");
                end else begin
                    e = exp_q.pop_front();
                    check("err", 64'(err), 64'(e.err));
                    check("beats", 64'(beat_cnt - e.base), 64'(e.beats));
                    if (e.load && !e.err) check("load_q", q, e.q);
                    if (!e.load && !e.err && q_known) check("store_q_held", q, last_q);
                    if (e.lat > 0) check("latency", 64'(cyc - e.t_acc), 64'(e.lat));
                    if (e.load && !e.err) begin
                        last_q = e.q; q_known = 1;
                    end else if (e.err) begin
                        q_known = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [2:0] s, input logic w,
                         input logic [63:0] dd, input bit inj, input bit now);
        int   guard, n, off;
        bit   legal, split;
        exp_t e;
        if (!now) @(negedge clk);
        adr = a; size = s; we = w; d = dd; req = 1;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready_o=0 want 1");
            req = 0;
            return;
        end
        legal = (s <= 3'd3);
        n     = 1 << s[1:0];
        off   = int'(a[2:0]);
        split = (off + n) > 8;
        e.q = '0; e.load = !w; e.t_acc = cyc; e.base = beat_cnt;
        if (!legal) begin
            e.err = 1; e.beats = 0; e.lat = 1;
        end else begin
            e.err   = inj;
            e.beats = (split && !inj) ? 2 : 1;
            e.lat   = (max_wait == 0 && force_wait <= 0) ? ((split && !inj) ? 5 : 3) : 0;
            for (int i = 0; i < n; i++) begin
                if (w) ref_mem[a + 64'(i)] = dd[8*i +: 8];
                else   e.q[8*i +: 8] = ref_rd(a + 64'(i));
            end
            inject_err = inj;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 req = 0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL completion_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        logic [63:0] a, dd;
        logic [2:0]  s;
        logic        w;
        bit          inj;
        int          r;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_q", q, 64'd0);
        rst_n = 1;

        // 1: aligned WORD load
        preload(64'h1000, 64'h11223344_55667788);
        blog.delete();
        issue(64'h1004, 3'd2, 0, '0, 0, 0);
        wait_done();
        check("t1_nbeats", 64'(blog.size()), 64'd1);
        if (blog.size() >= 1) begin
            check("t1_adr", blog[0].adr, 64'h1000);
            check("t1_be", 64'(blog[0].be), 64'hF0);
        end

        // 2: split DWORD load
        preload(64'h1000, 64'h88776655_44332211);
        preload(64'h1008, 64'hFFEEDDCC_BBAA9988);
        blog.delete();
        issue(64'h1003, 3'd3, 0, '0, 0, 0);
        wait_done();
        check("t2_nbeats", 64'(blog.size()), 64'd2);
        if (blog.size() >= 2) begin
            check("t2_adr0", blog[0].adr, 64'h1000);
            check("t2_be0", 64'(blog[0].be), 64'hF8);
            check("t2_adr1", blog[1].adr, 64'h1008);
            check("t2_be1", 64'(blog[1].be), 64'h07);
        end

        // 3: split HWORD store
        blog.delete();
        issue(64'h2007, 3'd1, 1, 64'hBEEF, 0, 0);
        wait_done();
        check("t3_nbeats", 64'(blog.size()), 64'd2);
        if (blog.size() >= 2) begin
            check("t3_adr0", blog[0].adr, 64'h2000);
            check("t3_be0", 64'(blog[0].be), 64'h80);
            check("t3_lane7", 64'(blog[0].d[63:56]), 64'hEF);
            check("t3_adr1", blog[1].adr, 64'h2008);
            check("t3_be1", 64'(blog[1].be), 64'h01);
            check("t3_lane0", 64'(blog[1].d[7:0]), 64'hBE);
        end
        issue(64'h2007, 3'd1, 0, '0, 0, 0);
        wait_done();

        // 4: 3-cycle ack stall on both beats
        force_wait = 3;
        issue(64'h1005, 3'd3, 0, '0, 0, 0);
        wait_done();
        issue(64'h2006, 3'd2, 1, 64'hCAFEF00D, 0, 0);
        wait_done();
        force_wait = -1;

        // 5: beat0 error suppresses beat1; illegal size traps without a beat
        issue(64'h1006, 3'd2, 0, '0, 1, 0);
        wait_done();
        issue(64'h1000, 3'b100, 0, '0, 0, 0);
        wait_done();

        // address wrap on the second beat
        preload(64'hFFFF_FFFF_FFFF_FFF8, 64'h0102030405060708);
        issue(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 0, '0, 0, 0);
        wait_done();

        // 6: reset during RSP1 of a split load
        issue(64'h1003, 3'd3, 0, '0, 0, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("mid_rst_mem_be", 64'(bus.mem_be), 64'd0);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_q", q, 64'd0);
        exp_q.delete();
        inject_err = 0;
        last_q = '0; q_known = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        issue(64'h0, 3'd3, 0, '0, 0, 0);
        guard = 0;
        while (!rvalid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("b2b_ready", 64'(ready), 64'd1);
        issue(64'h1001, 3'd3, 0, '0, 0, 1);
        wait_done();

        // randomized traffic against the byte-memory model
        for (int k = 0; k < 250; k++) begin
            max_wait = $urandom_range(2, 0);
            a  = 64'h3000 + 64'($urandom_range(63, 0));
            r  = $urandom_range(9, 0);
            s  = (r < 8) ? 3'(r % 4) : 3'(4 + $urandom_range(3, 0));
            w  = 1'($urandom_range(1, 0));
            dd = {$urandom, $urandom};
            inj = !w && ($urandom_range(9, 0) == 0);
            issue(a, s, w, dd, inj, 0);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
